// File: rtl/multiport_regfile_pkg.sv
// Shared types and default geometry for the multi-port register file.
// Pure declarations; no logic.
package regfile_pkg;

    localparam int DEF_W = 8;
    localparam int DEF_N = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/multiport_regfile_if.sv
// Decode/writeback-facing bus of the register file.
// Master drives writes, read addresses and clear requests; slave returns read data and status.
interface multiport_regfile_if
    import regfile_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N
);
    logic         write0;
    logic [N-1:0] wreg0;
    logic [W-1:0] wdata0;
    logic         write1;
    logic [N-1:0] wreg1;
    logic [W-1:0] wdata1;
    logic [N-1:0] rreg1;
    logic [N-1:0] rreg2;
    logic [W-1:0] rdata1;
    logic [W-1:0] rdata2;
    logic         clr_start;
    logic         clr_busy;
    logic         wr_drop;

    modport master (
        output write0, wreg0, wdata0, write1, wreg1, wdata1,
        output rreg1, rreg2, clr_start,
        input  rdata1, rdata2, clr_busy, wr_drop
    );

    modport slave (
        input  write0, wreg0, wdata0, write1, wreg1, wdata1,
        input  rreg1, rreg2, clr_start,
        output rdata1, rdata2, clr_busy, wr_drop
    );
endinterface

// File: rtl/multiport_regfile_clear_fsm.sv
// Sequential clear engine: sweeps one entry per cycle for 2**N cycles after clr_start.
// Latency: busy rises the cycle after the start edge; writes during the sweep are dropped and flagged a cycle later.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr_start,
    input  logic         i_wr_req,
    output logic         o_clr_busy,
    output logic         o_wr_drop,
    output logic         o_clr_en,
    output logic [N-1:0] o_clr_addr
);
    localparam logic [N-1:0] ONE = 1;

    clr_state_t   r_state;
    logic [N-1:0] r_ptr;
    logic         r_busy;
    logic         r_drop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_clr_start) begin
                        r_state <= CLEAR;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    // clr_start is deliberately ignored here so a sweep is never restarted
                    r_drop <= i_wr_req;
                    r_ptr  <= r_ptr + ONE;
                    if (r_ptr == '1) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_clr_busy = r_busy;
    assign o_wr_drop  = r_drop;
    assign o_clr_en   = (r_state == CLEAR);
    assign o_clr_addr = r_ptr;

endmodule

// File: rtl/multiport_regfile.sv
// 2-read/2-write register file with optional zero register, write bypass and a sequential clear engine.
// Reads are combinational (latency 0); writes commit on the clock edge and are discarded while clearing.
module multiport_regfile
    import regfile_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int N       = DEF_N,
    parameter bit R0_ZERO = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    multiport_regfile_if.slave  bus
);
    localparam int DEPTH = 2 ** N;

    logic [W-1:0] r_mem [DEPTH];

    logic         w_clr_en;
    logic [N-1:0] w_clr_addr;
    logic         w_clr_busy;
    logic         w_we0;
    logic         w_we1;
    logic [W-1:0] w_rdata1;
    logic [W-1:0] w_rdata2;

    regfile_clear_fsm #(.N(N)) u_clear_fsm (
        .clk        (clk),
        .reset      (reset),
        .i_clr_start(bus.clr_start),
        .i_wr_req   (bus.write0 | bus.write1),
        .o_clr_busy (w_clr_busy),
        .o_wr_drop  (bus.wr_drop),
        .o_clr_en   (w_clr_en),
        .o_clr_addr (w_clr_addr)
    );

    assign w_we0 = bus.write0 && !w_clr_en && !(R0_ZERO && (bus.wreg0 == '0));
    assign w_we1 = bus.write1 && !w_clr_en && !(R0_ZERO && (bus.wreg1 == '0));

    // Port 1 is assigned last so it wins a same-address collision
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_clr_en) begin
            r_mem[w_clr_addr] <= '0;
        end else begin
            if (w_we0) r_mem[bus.wreg0] <= bus.wdata0;
            if (w_we1) r_mem[bus.wreg1] <= bus.wdata1;
        end
    end

    function automatic logic [W-1:0] read_port(input logic [N-1:0] addr);
        logic [W-1:0] v;
        v = r_mem[addr];
        if (BYPASS) begin
            if (w_we1 && (bus.wreg1 == addr))      v = bus.wdata1;
            else if (w_we0 && (bus.wreg0 == addr)) v = bus.wdata0;
        end
        if (R0_ZERO && (addr == '0)) v = '0;
        if (!reset)                  v = '0;
        return v;
    endfunction

    always_comb begin
        w_rdata1 = '0;
        w_rdata2 = '0;
        w_rdata1 = read_port(bus.rreg1);
        w_rdata2 = read_port(bus.rreg2);
    end

    assign bus.rdata1   = w_rdata1;
    assign bus.rdata2   = w_rdata2;
    assign bus.clr_busy = w_clr_busy;

endmodule
